// File: rtl/mesi_pkg.sv
// Shared types and pure protocol helpers for the MESI snoopy controller.
package mesi_pkg;

    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        BUS_NONE           = 3'd0,
        BUS_READ           = 3'd1,
        BUS_READ_EXCLUSIVE = 3'd2,
        BUS_INVALIDATE     = 3'd3,
        BUS_WRITEBACK      = 3'd4
    } bus_command_t;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        BUSY,
        DONE
    } fsm_state_t;

    function automatic state_t snoop_next_state(input state_t state,
                                                input bus_command_t command);
        snoop_next_state = state;
        case (command)
            BUS_READ:
                if (state != INVALID) snoop_next_state = SHARED;
            BUS_READ_EXCLUSIVE, BUS_INVALIDATE:
                snoop_next_state = INVALID;
            default: ;
        endcase
    endfunction

    function automatic logic cpu_hit_permitted(input state_t state,
                                               input logic write);
        return (state != INVALID) &&
               (!write || state == EXCLUSIVE || state == MODIFIED);
    endfunction

endpackage

// File: rtl/mesi_state_array.sv
// Direct-mapped tag/state store with separate CPU and snoop ports.
module mesi_state_array
    import mesi_pkg::*;
#(
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] cpu_index,
    output logic [TAG_WIDTH-1:0]   cpu_tag,
    output state_t                 cpu_state,
    input  logic [INDEX_WIDTH-1:0] snoop_index,
    output logic [TAG_WIDTH-1:0]   snoop_tag,
    output state_t                 snoop_state,
    input  logic                   cpu_update,
    input  logic [INDEX_WIDTH-1:0] cpu_update_index,
    input  logic [TAG_WIDTH-1:0]   cpu_update_tag,
    input  state_t                 cpu_update_state,
    input  logic                   snoop_update,
    input  logic [INDEX_WIDTH-1:0] snoop_update_index,
    input  state_t                 snoop_update_state
);

    localparam int LINES = 2 ** INDEX_WIDTH;

    logic [TAG_WIDTH-1:0] tags   [LINES];
    state_t               states [LINES];

    assign cpu_tag     = tags[cpu_index];
    assign cpu_state   = states[cpu_index];
    assign snoop_tag   = tags[snoop_index];
    assign snoop_state = states[snoop_index];

    // Snoop write is applied last so it wins on a shared index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                tags[i]   <= '0;
                states[i] <= INVALID;
            end
        end else begin
            if (cpu_update) begin
                tags[cpu_update_index]   <= cpu_update_tag;
                states[cpu_update_index] <= cpu_update_state;
            end
            if (snoop_update) states[snoop_update_index] <= snoop_update_state;
        end
    end

endmodule

// File: rtl/mesi_snoopy_controller.sv
// MESI invalidate controller: CPU lookup, bus sequencing and snoop replies
// for one direct-mapped private cache.
module mesi_snoopy_controller
    import mesi_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 16,
    parameter  int INDEX_WIDTH   = 4,
    localparam int TAG_WIDTH     = ADDRESS_WIDTH - INDEX_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_valid,
    input  logic                     cpu_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    output logic                     cpu_ready,
    output logic                     cpu_done,
    output logic                     bus_request,
    input  logic                     bus_grant,
    output bus_command_t             bus_command,
    output logic [ADDRESS_WIDTH-1:0] bus_address,
    input  logic                     bus_shared,
    input  logic                     bus_done,
    input  logic                     snoop_valid,
    input  logic [2:0]               snoop_command,
    input  logic [ADDRESS_WIDTH-1:0] snoop_address,
    output logic                     snoop_shared,
    output logic                     snoop_flush,
    output logic                     snoop_ack
);

    fsm_state_t               fsm, fsm_next;
    bus_command_t             command_q, command_next;
    bus_command_t             fetch_q, fetch_next;
    logic [ADDRESS_WIDTH-1:0] request_address, request_next;
    logic [ADDRESS_WIDTH-1:0] victim_address, victim_next;
    logic                     hit_q, hit_next;

    logic [TAG_WIDTH-1:0]     line_tag, snoop_line_tag;
    state_t                   line_state, snoop_line_state;
    logic                     cpu_update;
    logic [INDEX_WIDTH-1:0]   update_index;
    logic [TAG_WIDTH-1:0]     update_tag;
    state_t                   update_state;

    bus_command_t snoop_op;
    logic         cpu_hit, accept;
    logic         snoop_hit, snoop_responds, snoop_flushes, snoop_kills;

    mesi_state_array #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_array (
        .clock             (clock),
        .reset             (reset),
        .cpu_index         (cpu_address[INDEX_WIDTH-1:0]),
        .cpu_tag           (line_tag),
        .cpu_state         (line_state),
        .snoop_index       (snoop_address[INDEX_WIDTH-1:0]),
        .snoop_tag         (snoop_line_tag),
        .snoop_state       (snoop_line_state),
        .cpu_update        (cpu_update),
        .cpu_update_index  (update_index),
        .cpu_update_tag    (update_tag),
        .cpu_update_state  (update_state),
        .snoop_update      (snoop_responds),
        .snoop_update_index(snoop_address[INDEX_WIDTH-1:0]),
        .snoop_update_state(snoop_next_state(snoop_line_state, snoop_op))
    );

    assign snoop_op  = bus_command_t'(snoop_command);
    assign snoop_hit = snoop_valid && snoop_line_state != INVALID &&
                       snoop_line_tag == snoop_address[ADDRESS_WIDTH-1:INDEX_WIDTH];
    assign snoop_responds = snoop_hit && (snoop_op == BUS_READ ||
                            snoop_op == BUS_READ_EXCLUSIVE ||
                            snoop_op == BUS_INVALIDATE);
    assign snoop_flushes  = snoop_responds && snoop_line_state == MODIFIED;
    assign snoop_kills    = snoop_responds && snoop_op != BUS_READ;

    assign cpu_hit   = line_state != INVALID &&
                       line_tag == cpu_address[ADDRESS_WIDTH-1:INDEX_WIDTH];
    assign cpu_ready = fsm == IDLE && !snoop_valid && !reset;
    assign accept    = cpu_valid && cpu_ready;

    assign cpu_done    = hit_q || fsm == DONE;
    assign bus_request = fsm == REQUEST || fsm == BUSY;
    assign bus_command = (fsm == BUSY && bus_grant) ? command_q : BUS_NONE;
    assign bus_address = (command_q == BUS_WRITEBACK) ? victim_address
                                                      : request_address;

    always_comb begin
        fsm_next     = fsm;
        command_next = command_q;
        fetch_next   = fetch_q;
        request_next = request_address;
        victim_next  = victim_address;
        hit_next     = 1'b0;
        cpu_update   = 1'b0;
        update_index = request_address[INDEX_WIDTH-1:0];
        update_tag   = request_address[ADDRESS_WIDTH-1:INDEX_WIDTH];
        update_state = INVALID;
        unique case (fsm)
            IDLE: if (accept) begin
                request_next = cpu_address;
                victim_next  = {line_tag, cpu_address[INDEX_WIDTH-1:0]};
                fetch_next   = cpu_write ? BUS_READ_EXCLUSIVE : BUS_READ;
                if (cpu_hit && cpu_hit_permitted(line_state, cpu_write)) begin
                    hit_next = 1'b1;
                    if (cpu_write) begin
                        cpu_update   = 1'b1;
                        update_index = cpu_address[INDEX_WIDTH-1:0];
                        update_tag   = cpu_address[ADDRESS_WIDTH-1:INDEX_WIDTH];
                        update_state = MODIFIED;
                    end
                end else begin
                    fsm_next = REQUEST;
                    if (cpu_hit)
                        command_next = BUS_INVALIDATE;
                    else if (line_state == MODIFIED)
                        command_next = BUS_WRITEBACK;
                    else
                        command_next = cpu_write ? BUS_READ_EXCLUSIVE : BUS_READ;
                end
            end
            REQUEST: begin
                // A snoop may steal the line before we own the bus.
                if (command_q == BUS_INVALIDATE && snoop_kills &&
                    snoop_address == request_address)
                    command_next = BUS_READ_EXCLUSIVE;
                if (command_q == BUS_WRITEBACK && snoop_flushes &&
                    snoop_address == victim_address)
                    command_next = fetch_q;
                if (bus_grant) fsm_next = BUSY;
            end
            BUSY: if (bus_grant && bus_done) begin
                cpu_update = 1'b1;
                if (command_q == BUS_WRITEBACK) begin
                    update_tag   = victim_address[ADDRESS_WIDTH-1:INDEX_WIDTH];
                    update_state = INVALID;
                    command_next = fetch_q;
                    fsm_next     = REQUEST;
                end else begin
                    update_state = (command_q != BUS_READ) ? MODIFIED :
                                   bus_shared ? SHARED : EXCLUSIVE;
                    fsm_next     = DONE;
                end
            end
            DONE: fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm             <= IDLE;
            command_q       <= BUS_NONE;
            fetch_q         <= BUS_NONE;
            request_address <= '0;
            victim_address  <= '0;
            hit_q           <= 1'b0;
            snoop_ack       <= 1'b0;
            snoop_shared    <= 1'b0;
            snoop_flush     <= 1'b0;
        end else begin
            fsm             <= fsm_next;
            command_q       <= command_next;
            fetch_q         <= fetch_next;
            request_address <= request_next;
            victim_address  <= victim_next;
            hit_q           <= hit_next;
            snoop_ack       <= snoop_valid;
            snoop_shared    <= snoop_responds;
            snoop_flush     <= snoop_flushes;
        end
    end

endmodule
